// File: rtl/bus_coherence_ctrl.sv
// bus_coherence_ctrl: responder side of the two-dcache MSI coherence bus.
// One transaction is in flight at a time. Fills snoop the other cache
// first and either read RAM or take a cache-to-cache transfer that is
// written back to RAM in the same beat. Upgrades invalidate the other cache.
// Writebacks stream two words to RAM. Every data word is paced by dwait.
// All outputs are combinational from the registered state and ramstate.
module bus_coherence_ctrl #(
  parameter int CPUS     = 2,
  parameter int BLKWORDS = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [1:0]       dREN,
  input  logic [1:0]       dWEN,
  input  logic [1:0][31:0] daddr,
  input  logic [1:0][31:0] dstore,
  input  logic [1:0]       cctrans,
  input  logic [1:0]       ccwrite,
  output logic [1:0]       dwait,
  output logic [1:0][31:0] dload,
  output logic [1:0]       ccwait,
  output logic [1:0]       ccinv,
  output logic [1:0][31:0] ccsnoopaddr,
  output logic             ramREN,
  output logic             ramWEN,
  output logic [31:0]      ramaddr,
  output logic [31:0]      ramstore,
  input  logic [31:0]      ramload,
  input  logic [1:0]       ramstate
);

  // RAM handshake: only ACCESS completes a word; FREE, BUSY and ERROR all stall.
  localparam logic [1:0] RAM_ACCESS = 2'b10;

  typedef enum logic [3:0] {
    IDLE, SNOOP, RD0, RD1, C2C0, C2C1, INV, ACK, WB0, WB1
  } state_t;

  state_t     state_q, state_d;
  logic       req_q, req_d;      // cache currently served
  logic       rrptr_q, rrptr_d;  // cache served most recently
  logic       snp;               // the other cache, target of snoops
  logic       acc;
  logic       gnt;
  logic [1:0] cand;

  // dREN is implied by cctrans for fills; the block geometry is fixed at
  // two caches with two-word blocks, so these are carried but not decoded.
  localparam logic [7:0] GEOM = 8'(CPUS + BLKWORDS);
  logic unused_ok;
  assign unused_ok = &{1'b0, dREN, GEOM};

  assign snp  = ~req_q;
  assign acc  = (ramstate == RAM_ACCESS);
  assign cand = cctrans | dWEN;

  // Registered control: state, current requester and round-robin pointer.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      rrptr_q <= 1'b1;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      rrptr_q <= rrptr_d;
    end
  end

  // Arbitration, next-state logic and all bus outputs.
  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    rrptr_d     = rrptr_q;
    gnt         = 1'b0;
    dwait       = 2'b11;
    dload       = '0;
    ccwait      = 2'b00;
    ccinv       = 2'b00;
    ccsnoopaddr = '0;
    ramREN      = 1'b0;
    ramWEN      = 1'b0;
    ramaddr     = 32'h0;
    ramstore    = 32'h0;

    unique case (state_q)
      IDLE: begin
        if (|cand) begin
          // On a tie the cache that was not served last wins.
          gnt     = (&cand) ? ~rrptr_q : cand[1];
          req_d   = gnt;
          rrptr_d = gnt;
          if (cctrans[gnt]) state_d = ccwrite[gnt] ? INV : SNOOP;
          else              state_d = WB0;
        end
      end

      SNOOP: begin
        ccwait[snp]      = 1'b1;
        ccsnoopaddr[snp] = daddr[req_q];
        // The snooped cache answers with ccwrite if it owns the block.
        state_d = ccwrite[snp] ? C2C0 : RD0;
      end

      RD0, RD1: begin
        ramREN       = 1'b1;
        ramaddr      = daddr[req_q];
        dload[req_q] = ramload;
        dwait[req_q] = ~acc;
        if (acc) state_d = (state_q == RD0) ? RD1 : IDLE;
      end

      C2C0, C2C1: begin
        // Owner's data goes to memory and to the requester in the same beat.
        ccwait[snp]      = 1'b1;
        ccsnoopaddr[snp] = daddr[req_q];
        ramWEN           = 1'b1;
        ramaddr          = daddr[snp];
        ramstore         = dstore[snp];
        dload[req_q]     = dstore[snp];
        if (acc) begin
          dwait   = 2'b00;
          state_d = (state_q == C2C0) ? C2C1 : IDLE;
        end
      end

      INV: begin
        ccwait[snp]      = 1'b1;
        ccinv[snp]       = 1'b1;
        ccsnoopaddr[snp] = daddr[req_q];
        state_d          = ACK;
      end

      ACK: begin
        // Release of ccwait[req] tells the requester its upgrade is done.
        ccwait[req_q]      = 1'b1;
        ccsnoopaddr[req_q] = daddr[req_q];
        state_d            = IDLE;
      end

      WB0, WB1: begin
        ramWEN       = 1'b1;
        ramaddr      = daddr[req_q];
        ramstore     = dstore[req_q];
        dwait[req_q] = ~acc;
        if (acc) state_d = (state_q == WB0) ? WB1 : IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: doc/bus_coherence_ctrl.md
# bus_coherence_ctrl

Responder end of the dcache coherence/memory interface. It arbitrates between two MSI dcaches and serves their snoop, fill, upgrade and writeback requests against a single RAM port. It issues ccwait/ccinv/ccsnoopaddr to the snooped cache, performs cache-to-cache transfers with memory writeback, and paces every word with dwait. The block sits between the per-core caches and the RAM model.

## Interface
Parameters:
- CPUS, 2, number of dcaches served (fixed at 2; arbitration logic is 2-way)
- BLKWORDS, 2, words per block; word select is daddr[2]

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  asynchronous, active-high reset
- dREN  in  [1:0]  per-cache read request
- dWEN  in  [1:0]  per-cache write request
- daddr  in  [1:0][31:0]  per-cache word address
- dstore  in  [1:0][31:0]  per-cache write data
- cctrans  in  [1:0]  coherent transaction request
- ccwrite  in  [1:0]  when not snooped: upgrade (S->M) request; when snooped: "I hold M, supplying block"
- dwait  out  [1:0]  0 = this cache's current word completes this cycle
- dload  out  [1:0][31:0]  read data to each cache
- ccwait  out  [1:0]  cache is being snooped / acknowledged
- ccinv  out  [1:0]  snooped cache must invalidate
- ccsnoopaddr  out  [1:0][31:0]  snoop address
- ramREN, ramWEN  out  1  RAM strobes
- ramaddr, ramstore  out  32  RAM address and write data
- ramload  in  32  RAM read data
- ramstate  in  2  FREE/BUSY/ACCESS/ERROR; ACCESS = word done this cycle

## Operation
- States: IDLE, SNOOP, RD0, RD1, C2C0, C2C1, INV, ACK, WB0, WB1. Registers: state, req (1 b), rrptr (1 b, last served).
- In IDLE, a candidate is cache i with cctrans[i] or dWEN[i]. If both caches are candidates, grant ~rrptr. Latch req and set rrptr <= req on grant. snp = ~req.
- Grant with cctrans & ~ccwrite -> SNOOP (fill).
- Grant with cctrans & ccwrite -> INV (upgrade).
- Grant with dWEN & ~cctrans -> WB0 (eviction/flush).
- SNOOP: ccwait[snp]=1, ccsnoopaddr[snp]=daddr[req], ccinv[snp]=0; duration 1 cycle. At its end, sample ccwrite[snp]: 1 -> C2C0, 0 -> RD0.
- RD0/RD1: ramREN=1, ramaddr=daddr[req], dload[req]=ramload. dwait[req]=~(ramstate==ACCESS). Each ACCESS advances RD0->RD1->IDLE.
- C2C0/C2C1: ccwait[snp], ccsnoopaddr[snp] held. ramWEN=1, ramaddr=daddr[snp], ramstore=dstore[snp], dload[req]=dstore[snp]. On ACCESS, dwait[snp]=dwait[req]=0 in the same cycle; C2C0->C2C1->IDLE. The memory copy and the requester's copy are written together.
- INV: ccwait[snp]=1, ccinv[snp]=1, ccsnoopaddr[snp]=daddr[req]; 1 cycle -> ACK.
- ACK: ccwait[req]=1, ccsnoopaddr[req]=daddr[req], ccinv[req]=0; 1 cycle -> IDLE. The falling edge of ccwait[req] completes the requester's upgrade.
- WB0/WB1: ramWEN=1, ramaddr=daddr[req], ramstore=dstore[req]. dwait[req] drops on ACCESS; WB0->WB1->IDLE.
- ramstate==ERROR is treated as BUSY (no advance, dwait stays 1).
- Outputs of the non-served cache: dwait=1, ccwait=0, ccinv=0, ccsnoopaddr=0, dload=0.
- Requests arriving while not IDLE are held by the caches. The controller never drops or preempts an in-flight transaction.

## Timing
- Reset (async, immediate): state=IDLE, rrptr=1 (cache 0 wins the first tie). dwait=2'b11, ccwait=0, ccinv=0, ccsnoopaddr=0, dload=0, ramREN=ramWEN=0, ramaddr=ramstore=0.
- Reset mid-transaction aborts to IDLE with all strobes low in the same instant. No partial state survives.
- Outputs are combinational from the registered state plus ramstate. Transitions occur on CLK rising edge.
- Fill latency = 1 (SNOOP) + 2 RAM beats. With RAM ACCESS every cycle, the request is granted at edge 0 and dwait[req] is low in cycles 2 and 3.
- Upgrade: 2 cycles (INV, ACK), no RAM traffic.
- Writeback: 2 RAM beats.
- Grant decision is made in IDLE only. There is at least one IDLE cycle between transactions.
- Simultaneous cctrans from both caches: serve one fully, then the other. Strict alternation under continuous contention.

## Test plan
- Reset with both caches requesting: after RST falls, cache 0 is granted; ccwait[1]=1 for 1 cycle with ccsnoopaddr[1]=daddr[0]=0x100; then 2 RAM reads 0x100/0x104; dwait[0] low on each ACCESS.
- Cache-to-cache: cache 1 asserts ccwrite while snooped on 0x200, driving 0xAAAA then 0xBBBB. Required: ramWEN on 0x200/0x204, dload[0]=0xAAAA/0xBBBB, dwait[0] and dwait[1] low together.
- Upgrade: cache 1 asserts cctrans & ccwrite for 0x300. Required: ccinv[0]=ccwait[0]=1 for 1 cycle, then ccwait[1]=1 for 1 cycle; no ramREN/ramWEN.
- RAM latency 3 cycles (BUSY, BUSY, ACCESS): dwait stays 1 through BUSY and ERROR cycles, drops only on ACCESS; the word does not advance early.
- Contention: both caches hold cctrans for 4 transactions. Grants alternate 0,1,0,1. Concurrently, dWEN flush beats complete in order.
- Async RST asserted during C2C1: all outputs return to reset values immediately; after release, the controller is in IDLE and the next request is served normally.
